// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional feature macro ALU_OPCHECK_EN: reject opcodes 3'b101..3'b111 without driving the ALU.
module alu_arbiter #(
  parameter int DATA_W = 65,
  parameter int OP_W   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          reqValid,
  output logic [1:0]          reqReady,
  input  logic [2*OP_W-1:0]   reqOp,
  input  logic [2*DATA_W-1:0] reqA,
  input  logic [2*DATA_W-1:0] reqB,
  output logic [1:0]          rspValid,
  input  logic [1:0]          rspReady,
  output logic [DATA_W-1:0]   rspResult,
  output logic                rspZero,
  output logic                rspErr,
  output logic [OP_W-1:0]     aluOP,
  output logic [DATA_W-1:0]   aluA,
  output logic [DATA_W-1:0]   aluB,
  input  logic [DATA_W-1:0]   aluResult,
  input  logic                aluZero,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} stateT;

  stateT             state;
  logic              lastGrant;
  logic              curId;
  logic              grant;
  logic              anyValid;
  logic [OP_W-1:0]   selOp;
  logic [DATA_W-1:0] selA;
  logic [DATA_W-1:0] selB;

  // On a tie the port that was not served last wins.
  always_comb begin
    anyValid = |reqValid;
    grant    = reqValid[1] & (~reqValid[0] | ~lastGrant);
    selOp    = grant ? reqOp[2*OP_W-1:OP_W]     : reqOp[OP_W-1:0];
    selA     = grant ? reqA[2*DATA_W-1:DATA_W]  : reqA[DATA_W-1:0];
    selB     = grant ? reqB[2*DATA_W-1:DATA_W]  : reqB[DATA_W-1:0];
    reqReady = '0;
    if (state == IDLE && anyValid) begin
      reqReady[grant] = 1'b1;
    end
  end

`ifdef ALU_OPCHECK_EN
  logic illegalOp;

  always_comb begin
    illegalOp = (selOp >= OP_W'(5));
  end
`else
  assign rspErr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lastGrant <= 1'b1;
      curId     <= 1'b0;
      rspValid  <= '0;
      rspResult <= '0;
      rspZero   <= 1'b0;
      aluOP     <= '0;
      aluA      <= '0;
      aluB      <= '0;
      busy      <= 1'b0;
`ifdef ALU_OPCHECK_EN
      rspErr    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (anyValid) begin
            curId     <= grant;
            lastGrant <= grant;
            busy      <= 1'b1;
`ifdef ALU_OPCHECK_EN
            // Illegal opcodes answer straight away and leave the ALU inputs untouched.
            if (illegalOp) begin
              state           <= RESP;
              rspValid[grant] <= 1'b1;
              rspResult       <= '0;
              rspZero         <= 1'b0;
              rspErr          <= 1'b1;
            end else begin
              state <= EXEC;
              aluOP <= selOp;
              aluA  <= selA;
              aluB  <= selB;
            end
`else
            state <= EXEC;
            aluOP <= selOp;
            aluA  <= selA;
            aluB  <= selB;
`endif
          end
        end
        EXEC: begin
          rspResult       <= aluResult;
          rspZero         <= aluZero;
          rspValid[curId] <= 1'b1;
          state           <= RESP;
`ifdef ALU_OPCHECK_EN
          rspErr          <= 1'b0;
`endif
        end
        RESP: begin
          if (rspReady[curId]) begin
            rspValid <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests push expected responses, a monitor pops them.
// Works with or without ALU_OPCHECK_EN defined.
module tb_alu_arbiter;

  localparam int DATA_W = 65;
  localparam int OP_W   = 3;

  logic                clk;
  logic                rst_n;
  logic [1:0]          reqValid;
  logic [1:0]          reqReady;
  logic [2*OP_W-1:0]   reqOp;
  logic [2*DATA_W-1:0] reqA;
  logic [2*DATA_W-1:0] reqB;
  logic [1:0]          rspValid;
  logic [1:0]          rspReady;
  logic [DATA_W-1:0]   rspResult;
  logic                rspZero;
  logic                rspErr;
  logic [OP_W-1:0]     aluOP;
  logic [DATA_W-1:0]   aluA;
  logic [DATA_W-1:0]   aluB;
  logic [DATA_W-1:0]   aluResult;
  logic                aluZero;
  logic                busy;

  typedef struct {
    logic [1:0]        port;
    logic [DATA_W-1:0] res;
    logic              zero;
    logic              err;
  } expT;

  expT expQ[$];
  int  checkCount = 0;
  int  passCount  = 0;

  alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady),
    .reqOp(reqOp), .reqA(reqA), .reqB(reqB),
    .rspValid(rspValid), .rspReady(rspReady),
    .rspResult(rspResult), .rspZero(rspZero), .rspErr(rspErr),
    .aluOP(aluOP), .aluA(aluA), .aluB(aluB),
    .aluResult(aluResult), .aluZero(aluZero),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the external ALU: 000 add, 001 sub, 010 and, 011 or, 100 pass B, others xor.
  always_comb begin
    case (aluOP)
      3'b000:  aluResult = aluA + aluB;
      3'b001:  aluResult = aluA - aluB;
      3'b010:  aluResult = aluA & aluB;
      3'b011:  aluResult = aluA | aluB;
      3'b100:  aluResult = aluB;
      default: aluResult = aluA ^ aluB;
    endcase
    aluZero = (aluResult == '0);
  end

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic pushExp(input int port, input logic [DATA_W-1:0] res,
                         input logic zero, input logic err);
    expT e;
    e.port = 2'(1 << port);
    e.res  = res;
    e.zero = zero;
    e.err  = err;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input int port, input logic [OP_W-1:0] op,
                               input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    reqOp[port*OP_W +: OP_W]       = op;
    reqA[port*DATA_W +: DATA_W]    = a;
    reqB[port*DATA_W +: DATA_W]    = b;
    reqValid[port]                 = 1'b1;
  endtask

  task automatic waitRsp(input int port, input int expLat, input string name);
    int lat = 1;
    while (!rspValid[port] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput(name, DATA_W'(lat), DATA_W'(expLat));
  endtask

  // Issues one request, waits for acceptance and response, and checks the latency.
  task automatic doOp(input int port, input logic [OP_W-1:0] op,
                      input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input logic [DATA_W-1:0] expRes, input logic expZero,
                      input logic expErr, input int expLat);
    int n = 0;
    applyStimulus(port, op, a, b);
    #1;
    while (!reqReady[port] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("accept", DATA_W'(reqReady[port]), DATA_W'(1));
    pushExp(port, expRes, expZero, expErr);
    @(posedge clk); #1;
    reqValid[port] = 1'b0;
    waitRsp(port, expLat, "latency");
    if (rspReady[port]) begin
      @(posedge clk); #1;
      checkOutput("retireBusy", DATA_W'(busy), DATA_W'(0));
      checkOutput("retireValid", DATA_W'(rspValid), DATA_W'(0));
    end
  endtask

  // Both ports request together; port 0 is expected to win this tie.
  task automatic doTie(input logic [OP_W-1:0] op0, input logic [DATA_W-1:0] a0,
                       input logic [DATA_W-1:0] b0, input logic [DATA_W-1:0] r0,
                       input logic [OP_W-1:0] op1, input logic [DATA_W-1:0] a1,
                       input logic [DATA_W-1:0] b1, input logic [DATA_W-1:0] r1);
    applyStimulus(0, op0, a0, b0);
    applyStimulus(1, op1, a1, b1);
    #1;
    checkOutput("tieGrant", DATA_W'(reqReady), DATA_W'(2'b01));
    pushExp(0, r0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reqValid[0] = 1'b0;
    checkOutput("execNoReady", DATA_W'(reqReady), DATA_W'(0));
    waitRsp(0, 2, "tieLat0");
    checkOutput("respNoReady", DATA_W'(reqReady), DATA_W'(0));
    @(posedge clk); #1;
    checkOutput("secondGrant", DATA_W'(reqReady), DATA_W'(2'b10));
    pushExp(1, r1, 1'b0, 1'b0);
    @(posedge clk); #1;
    reqValid[1] = 1'b0;
    waitRsp(1, 2, "tieLat1");
    @(posedge clk); #1;
  endtask

  task automatic pulseReset;
    rst_n    = 1'b0;
    reqValid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Monitor: every completed response handshake is compared against the scoreboard head.
  always @(negedge clk) begin
    expT e;
    if (rst_n && (rspValid & rspReady) != 2'b00) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedRsp", DATA_W'(rspValid), DATA_W'(0));
      end else begin
        e = expQ.pop_front();
        checkOutput("rspPort", DATA_W'(rspValid), DATA_W'(e.port));
        checkOutput("rspResult", rspResult, e.res);
        checkOutput("rspZero", DATA_W'(rspZero), DATA_W'(e.zero));
        checkOutput("rspErr", DATA_W'(rspErr), DATA_W'(e.err));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    reqValid = '0;
    reqOp    = '0;
    reqA     = '0;
    reqB     = '0;
    rspReady = 2'b11;
    @(posedge clk); #1;
    checkOutput("rstReqReady", DATA_W'(reqReady), DATA_W'(0));
    checkOutput("rstRspValid", DATA_W'(rspValid), DATA_W'(0));
    checkOutput("rstResult", rspResult, DATA_W'(0));
    checkOutput("rstZero", DATA_W'(rspZero), DATA_W'(0));
    checkOutput("rstErr", DATA_W'(rspErr), DATA_W'(0));
    checkOutput("rstAluOP", DATA_W'(aluOP), DATA_W'(0));
    checkOutput("rstAluA", aluA, DATA_W'(0));
    checkOutput("rstAluB", aluB, DATA_W'(0));
    checkOutput("rstBusy", DATA_W'(busy), DATA_W'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] basic add on port 0");
    doOp(0, 3'b000, 65'd5, 65'd7, 65'd12, 1'b0, 1'b0, 2);
    checkOutput("aluOpHeld", DATA_W'(aluOP), DATA_W'(3'b000));
    checkOutput("aluAHeld", aluA, DATA_W'(5));

    $display("[TB] tie straight after reset");
    pulseReset();
    doTie(3'b001, 65'd9, 65'd4, 65'd5, 3'b010, 65'hF, 65'h3, 65'h3);
    doTie(3'b000, 65'd1, 65'd1, 65'd2, 3'b011, 65'hF0, 65'h0F, 65'hFF);

    $display("[TB] full-width operands");
    doOp(1, 3'b000, 65'h1_0000_0000_0000_0001, 65'h1_0000_0000_0000_0000,
         65'h1, 1'b0, 1'b0, 2);
    doOp(0, 3'b010, 65'h1_FFFF_FFFF_FFFF_FFFF, 65'h1_8000_0000_0000_0001,
         65'h1_8000_0000_0000_0001, 1'b0, 1'b0, 2);

    $display("[TB] back-pressure");
    rspReady = 2'b00;
    doOp(1, 3'b000, 65'd100, 65'd23, 65'd123, 1'b0, 1'b0, 2);
    for (int i = 0; i < 5; i++) begin
      rspReady = (i < 2) ? 2'b01 : 2'b00;
      @(posedge clk); #1;
      checkOutput("bpValid", DATA_W'(rspValid), DATA_W'(2'b10));
      checkOutput("bpResult", rspResult, DATA_W'(123));
      checkOutput("bpBusy", DATA_W'(busy), DATA_W'(1));
    end
    rspReady = 2'b11;
    @(posedge clk); #1;
    checkOutput("bpRetireBusy", DATA_W'(busy), DATA_W'(0));
    checkOutput("bpRetireValid", DATA_W'(rspValid), DATA_W'(0));

    $display("[TB] zero flag");
    doOp(0, 3'b100, 65'd0, 65'd0, 65'd0, 1'b1, 1'b0, 2);
    doOp(0, 3'b100, 65'd0, 65'd3, 65'd3, 1'b0, 1'b0, 2);

    $display("[TB] reset during EXEC");
    applyStimulus(0, 3'b000, 65'd3, 65'd4);
    #1;
    checkOutput("r5Accept", DATA_W'(reqReady), DATA_W'(2'b01));
    @(posedge clk); #1;
    checkOutput("r5ExecBusy", DATA_W'(busy), DATA_W'(1));
    rst_n    = 1'b0;
    reqValid = '0;
    #1;
    checkOutput("r5Valid", DATA_W'(rspValid), DATA_W'(0));
    checkOutput("r5Busy", DATA_W'(busy), DATA_W'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("r5NoRsp", DATA_W'(rspValid), DATA_W'(0));
    doTie(3'b001, 65'd20, 65'd8, 65'd12, 3'b011, 65'h100, 65'h1, 65'h101);

    $display("[TB] opcodes 101..111");
    doOp(1, 3'b100, 65'd0, 65'd9, 65'd9, 1'b0, 1'b0, 2);
`ifdef ALU_OPCHECK_EN
    doOp(0, 3'b110, 65'd6, 65'd2, 65'd0, 1'b0, 1'b1, 1);
    checkOutput("illegalAluOP", DATA_W'(aluOP), DATA_W'(3'b100));
    doOp(1, 3'b101, 65'd5, 65'd5, 65'd0, 1'b0, 1'b1, 1);
    doOp(0, 3'b000, 65'd2, 65'd2, 65'd4, 1'b0, 1'b0, 2);
`else
    doOp(0, 3'b110, 65'd6, 65'd2, 65'd4, 1'b0, 1'b0, 2);
    checkOutput("passAluOP", DATA_W'(aluOP), DATA_W'(3'b110));
    doOp(1, 3'b101, 65'd5, 65'd5, 65'd0, 1'b1, 1'b0, 2);
`endif

    repeat (2) @(posedge clk);
    checkOutput("queueEmpty", DATA_W'(expQ.size()), DATA_W'(0));
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
